// File: rtl/breadboard_sweep_pkg.sv
// Shared types and the golden truth table for the breadboard sweep checker.
// GOLDEN[i] is the expected {f4,f5,f6} when {w,x,y,z} = i.
package breadboard_sweep_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StSample,
    StDone
  } state_e;

  localparam int unsigned NUM_VECTORS = 16;

  // Entry 0 is the rightmost element.
  localparam logic [NUM_VECTORS-1:0][2:0] GOLDEN = {
    3'd4, 3'd0, 3'd1, 3'd2,
    3'd4, 3'd0, 3'd0, 3'd3,
    3'd4, 3'd0, 3'd1, 3'd2,
    3'd7, 3'd3, 3'd3, 3'd2
  };

  function automatic logic [2:0] golden_of(input logic [3:0] idx);
    return GOLDEN[idx];
  endfunction

endpackage

// File: rtl/breadboard_sweep_checker_if.sv
// Stimulus, response and verdict signals between the sweep checker and its environment.
// The checker uses the master view; the board side and the bench use the slave view.
interface breadboard_sweep_checker_if;

  logic       start;
  logic       w;
  logic       x;
  logic       y;
  logic       z;
  logic       f4;
  logic       f5;
  logic       f6;
  logic       busy;
  logic       done;
  logic       pass;
  logic [4:0] err_count;
  logic       err_valid;
  logic [3:0] first_err_idx;
  logic [2:0] first_err_got;

  modport master (
    input  start,
    input  f4,
    input  f5,
    input  f6,
    output w,
    output x,
    output y,
    output z,
    output busy,
    output done,
    output pass,
    output err_count,
    output err_valid,
    output first_err_idx,
    output first_err_got
  );

  modport slave (
    output start,
    output f4,
    output f5,
    output f6,
    input  w,
    input  x,
    input  y,
    input  z,
    input  busy,
    input  done,
    input  pass,
    input  err_count,
    input  err_valid,
    input  first_err_idx,
    input  first_err_got
  );

endinterface

// File: rtl/breadboard.sv
// Combinational f4/f5/f6 logic under test by the sweep checker.
module breadboard (
  input  logic w,
  input  logic x,
  input  logic y,
  input  logic z,
  output logic f4,
  output logic f5,
  output logic f6
);

  assign f4 = y & z;
  assign f5 = (~w & ~x) | (~y & ~z);
  assign f6 = (~w & ~x & (y | z)) | (x & ~y & z) | (w & ~x & ~y & ~z);

endmodule

// File: rtl/breadboard_sweep_checker.sv
// Walks all 16 {w,x,y,z} vectors, samples {f4,f5,f6} after SETTLE cycles each and
// reports a pass/fail verdict with error count and the first failing vector.
module breadboard_sweep_checker
  import breadboard_sweep_pkg::*;
#(
  parameter int unsigned SETTLE = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  breadboard_sweep_checker_if.master    bus
);

  if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
    $error("breadboard_sweep_checker: SETTLE must be in 1..15");
  end

  localparam logic [3:0] SettleLast = 4'(SETTLE - 1);
  localparam logic [3:0] IdxLast    = 4'(NUM_VECTORS - 1);

  state_e     state_q;
  logic [3:0] idx_q;
  logic [3:0] settle_q;
  logic       busy_q;
  logic       done_q;
  logic       pass_q;
  logic [4:0] err_count_q;
  logic       err_valid_q;
  logic [3:0] first_err_idx_q;
  logic [2:0] first_err_got_q;

  logic [2:0] sampled;
  logic       mismatch;

  assign sampled  = {bus.f4, bus.f5, bus.f6};
  assign mismatch = (sampled != golden_of(idx_q));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StIdle;
      idx_q           <= '0;
      settle_q        <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      pass_q          <= 1'b0;
      err_count_q     <= '0;
      err_valid_q     <= 1'b0;
      first_err_idx_q <= '0;
      first_err_got_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            state_q     <= StDrive;
            idx_q       <= '0;
            settle_q    <= '0;
            err_count_q <= '0;
            err_valid_q <= 1'b0;
            pass_q      <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        StDrive: begin
          if (settle_q == SettleLast) begin
            state_q <= StSample;
          end else begin
            settle_q <= settle_q + 4'd1;
          end
        end
        StSample: begin
          if (mismatch) begin
            err_count_q <= err_count_q + 5'd1;
            if (!err_valid_q) begin
              first_err_idx_q <= idx_q;
              first_err_got_q <= sampled;
              err_valid_q     <= 1'b1;
            end
          end
          if (idx_q == IdxLast) begin
            // Verdict folds in this last vector's compare, so it is valid alongside done.
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_count_q == '0) && !mismatch;
          end else begin
            state_q  <= StDrive;
            idx_q    <= idx_q + 4'd1;
            settle_q <= '0;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.w             = idx_q[3];
  assign bus.x             = idx_q[2];
  assign bus.y             = idx_q[1];
  assign bus.z             = idx_q[0];
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.pass          = pass_q;
  assign bus.err_count     = err_count_q;
  assign bus.err_valid     = err_valid_q;
  assign bus.first_err_idx = first_err_idx_q;
  assign bus.first_err_got = first_err_got_q;

endmodule

// File: tb/tb_breadboard_sweep_checker.sv
// Directed bench: real breadboard with injectable output faults, SETTLE=2 and SETTLE=1
// instances, verdicts checked against a scoreboard of predicted sweep results.
module tb_breadboard_sweep_checker;

  typedef struct {
    logic [4:0] cnt;
    logic       ev;
    logic [3:0] fidx;
    logic [2:0] fgot;
    logic       pass;
  } exp_t;

  localparam logic [2:0] REF [16] = '{3'd2, 3'd3, 3'd3, 3'd7, 3'd2, 3'd1, 3'd0, 3'd4,
                                     3'd3, 3'd0, 3'd0, 3'd4, 3'd2, 3'd1, 3'd0, 3'd4};

  logic clk = 1'b0;
  logic rst;
  int   fault;
  int   errors;
  int   checks;
  exp_t sb [$];

  always #5 clk = ~clk;

  breadboard_sweep_checker_if bus_a ();
  breadboard_sweep_checker_if bus_b ();

  logic [2:0] bb_a;
  logic [2:0] bb_b;

  // fault: 0 none, 1 f6 stuck at 0, 2 f4 inverted
  function automatic logic [2:0] apply_fault(input logic [2:0] v, input int f);
    case (f)
      1:       return v & 3'b110;
      2:       return v ^ 3'b100;
      default: return v;
    endcase
  endfunction

  breadboard u_bb_a (
    .w (bus_a.w), .x (bus_a.x), .y (bus_a.y), .z (bus_a.z),
    .f4(bb_a[2]), .f5(bb_a[1]), .f6(bb_a[0])
  );
  breadboard u_bb_b (
    .w (bus_b.w), .x (bus_b.x), .y (bus_b.y), .z (bus_b.z),
    .f4(bb_b[2]), .f5(bb_b[1]), .f6(bb_b[0])
  );

  assign {bus_a.f4, bus_a.f5, bus_a.f6} = apply_fault(bb_a, fault);
  assign {bus_b.f4, bus_b.f5, bus_b.f6} = bb_b;

  breadboard_sweep_checker #(.SETTLE(2)) u_dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  breadboard_sweep_checker #(.SETTLE(1)) u_dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  logic       mon_sel;
  logic [3:0] mon_vec;
  logic [2:0] mon_f;
  logic       mon_busy;
  logic       mon_done;
  logic       mon_pass;
  logic       mon_ev;
  logic [4:0] mon_cnt;
  logic [3:0] mon_fidx;
  logic [2:0] mon_fgot;

  always_comb begin
    if (mon_sel) begin
      mon_vec  = {bus_b.w, bus_b.x, bus_b.y, bus_b.z};
      mon_f    = {bus_b.f4, bus_b.f5, bus_b.f6};
      mon_busy = bus_b.busy;
      mon_done = bus_b.done;
      mon_pass = bus_b.pass;
      mon_ev   = bus_b.err_valid;
      mon_cnt  = bus_b.err_count;
      mon_fidx = bus_b.first_err_idx;
      mon_fgot = bus_b.first_err_got;
    end else begin
      mon_vec  = {bus_a.w, bus_a.x, bus_a.y, bus_a.z};
      mon_f    = {bus_a.f4, bus_a.f5, bus_a.f6};
      mon_busy = bus_a.busy;
      mon_done = bus_a.done;
      mon_pass = bus_a.pass;
      mon_ev   = bus_a.err_valid;
      mon_cnt  = bus_a.err_count;
      mon_fidx = bus_a.first_err_idx;
      mon_fgot = bus_a.first_err_got;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t predict(input int f);
    exp_t       e;
    logic [2:0] got;
    e = '{cnt: 5'd0, ev: 1'b0, fidx: 4'd0, fgot: 3'd0, pass: 1'b0};
    for (int i = 0; i < 16; i++) begin
      got = apply_fault(REF[i], f);
      if (got != REF[i]) begin
        if (!e.ev) begin
          e.fidx = 4'(i);
          e.fgot = got;
          e.ev   = 1'b1;
        end
        e.cnt++;
      end
    end
    e.pass = (e.cnt == 5'd0);
    return e;
  endfunction

  task automatic set_start(input logic sel, input logic v);
    if (sel) bus_b.start = v;
    else     bus_a.start = v;
  endtask

  task automatic check_reset(input string tag);
    check({tag, ":vec"},  32'(mon_vec), 0);
    check({tag, ":busy"}, 32'(mon_busy), 0);
    check({tag, ":done"}, 32'(mon_done), 0);
    check({tag, ":pass"}, 32'(mon_pass), 0);
    check({tag, ":cnt"},  32'(mon_cnt), 0);
    check({tag, ":ev"},   32'(mon_ev), 0);
    check({tag, ":fidx"}, 32'(mon_fidx), 0);
    check({tag, ":fgot"}, 32'(mon_fgot), 0);
  endtask

  task automatic check_verdict(input string tag);
    exp_t e;
    e = sb.pop_front();
    check({tag, ":cnt"},  32'(mon_cnt), 32'(e.cnt));
    check({tag, ":ev"},   32'(mon_ev), 32'(e.ev));
    check({tag, ":pass"}, 32'(mon_pass), 32'(e.pass));
    if (e.ev) begin
      check({tag, ":fidx"}, 32'(mon_fidx), 32'(e.fidx));
      check({tag, ":fgot"}, 32'(mon_fgot), 32'(e.fgot));
    end
  endtask

  // Waits for done after acceptance; returns cycle offset of done (k+j) and busy history.
  task automatic wait_done(input int s, input int f, input string tag, output int j);
    bit busy_ok;
    busy_ok = 1'b1;
    j = 1;
    while (!mon_done && j < 200) begin
      if (mon_busy !== 1'b1) busy_ok = 1'b0;
      if (j == 5 * (s + 1)) check({tag, ":vec4_before"}, 32'(mon_vec), 4);
      if (j == 1 + 5 * (s + 1)) check({tag, ":vec5_drive"}, 32'(mon_vec), 5);
      if (j == 1 + 5 * (s + 1) + s) begin
        check({tag, ":vec5_sample_vec"}, 32'(mon_vec), 5);
        check({tag, ":vec5_sample_f"}, 32'(mon_f), 32'(apply_fault(REF[5], f)));
      end
      @(negedge clk);
      j++;
    end
    check({tag, ":done_cycle"}, 32'(j), 32'(16 * (s + 1) + 1));
    check({tag, ":busy_span"}, 32'(busy_ok), 1);
    check({tag, ":busy_at_done"}, 32'(mon_busy), 0);
  endtask

  task automatic sweep(input logic sel, input int s, input int f, input string tag);
    int j;
    mon_sel = sel;
    fault   = f;
    sb.push_back(predict(f));
    @(negedge clk);
    set_start(sel, 1'b1);
    @(negedge clk);
    set_start(sel, 1'b0);
    wait_done(s, f, tag, j);
    check({tag, ":pass_at_done"}, 32'(mon_pass), 32'(sb[0].pass));
    @(negedge clk);
    check({tag, ":done_pulse"}, 32'(mon_done), 0);
    check({tag, ":idle_vec"}, 32'(mon_vec), 15);
    check_verdict(tag);
  endtask

  initial begin
    int j;
    int nd;
    errors      = 0;
    checks      = 0;
    fault       = 0;
    mon_sel     = 1'b0;
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
    rst         = 1'b1;
    repeat (2) @(negedge clk);
    // Reset must win over a simultaneous start.
    bus_a.start = 1'b1;
    bus_b.start = 1'b1;
    @(negedge clk);
    check_reset("reset_a");
    mon_sel = 1'b1;
    check_reset("reset_b");
    mon_sel     = 1'b0;
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
    rst         = 1'b0;
    @(negedge clk);
    check("idle_after_reset:busy", 32'(mon_busy), 0);

    sweep(1'b0, 2, 0, "clean_s2");
    sweep(1'b0, 2, 1, "f6_stuck0");
    sweep(1'b0, 2, 2, "f4_invert");

    // Reset in the middle of a sweep abandons it.
    fault = 0;
    @(negedge clk);
    bus_a.start = 1'b1;
    @(negedge clk);
    bus_a.start = 1'b0;
    j = 0;
    while (mon_vec !== 4'd7 && j < 100) begin
      @(negedge clk);
      j++;
    end
    check("rst_mid:reach7", 32'(mon_vec), 7);
    rst = 1'b1;
    @(negedge clk);
    check_reset("rst_mid");
    rst = 1'b0;
    nd  = 0;
    repeat (60) begin
      @(negedge clk);
      if (mon_done) nd++;
    end
    check("rst_mid:no_done", 32'(nd), 0);
    sweep(1'b0, 2, 0, "after_rst");

    // Stray starts mid-sweep and during DONE are ignored; held start chains a second sweep.
    sb.push_back(predict(0));
    sb.push_back(predict(0));
    @(negedge clk);
    bus_a.start = 1'b1;
    @(negedge clk);
    bus_a.start = 1'b0;
    j = 1;
    while (!mon_done && j < 200) begin
      if (mon_vec == 4'd4 && j < 20) bus_a.start = 1'b1;
      else bus_a.start = 1'b0;
      @(negedge clk);
      j++;
    end
    check("ignore:done_cycle", 32'(j), 49);
    bus_a.start = 1'b1;
    @(negedge clk);
    check("ignore:idle_busy", 32'(mon_busy), 0);
    check("ignore:idle_done", 32'(mon_done), 0);
    check_verdict("ignore_first");
    @(negedge clk);
    check("chain:accepted_busy", 32'(mon_busy), 1);
    check("chain:vec0", 32'(mon_vec), 0);
    bus_a.start = 1'b0;
    wait_done(2, 0, "chain", j);
    @(negedge clk);
    check_verdict("chain");

    sweep(1'b1, 1, 0, "clean_s1");

    check("scoreboard_empty", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
